// File: rtl/scope_capture_fifo_if.sv
// Control, trigger and read-port bundle for scope_capture_fifo.
// The master drives capture control and pops words; the slave is the capture block.
interface scope_capture_fifo_if #(
    parameter int NCH = 2,
    parameter int W   = 16,
    parameter int AW  = 10
);
    localparam int TCW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*W-1:0] ch_data;
    logic [31:0]      div_freq;
    logic             arm;
    logic             stop;
    logic             pause;
    logic             force_trig;
    logic [TCW-1:0]   trig_ch;
    logic [W-1:0]     trig_level;
    logic             trig_rising;
    logic [AW:0]      post_count;
    logic             rd_req;
    logic [NCH*W-1:0] rd_data;
    logic             rd_valid;
    logic [AW:0]      fifo_used;
    logic             fifo_empty;
    logic             fifo_full;
    logic [1:0]       state;
    logic             overflow;

    modport master (
        output ch_data, div_freq, arm, stop, pause, force_trig,
               trig_ch, trig_level, trig_rising, post_count, rd_req,
        input  rd_data, rd_valid, fifo_used, fifo_empty, fifo_full, state, overflow
    );

    modport slave (
        input  ch_data, div_freq, arm, stop, pause, force_trig,
               trig_ch, trig_level, trig_rising, post_count, rd_req,
        output rd_data, rd_valid, fifo_used, fifo_empty, fifo_full, state, overflow
    );
endinterface

// File: rtl/scope_capture_fifo.sv
// Multi-channel sampled capture into a FIFO with a rolling pre-trigger window,
// level/edge trigger and a counted post-trigger phase.
module scope_capture_fifo #(
    parameter int NCH = 2,
    parameter int W   = 16,
    parameter int AW  = 10
) (
    input logic              clk,
    input logic              reset_n,
    scope_capture_fifo_if.slave bus
);
    localparam int          DEPTH = 1 << AW;
    localparam int          TCW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_cnt, w_cnt_nxt;
    logic [AW:0]      r_rem, w_rem_nxt;
    logic [AW:0]      r_used;
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [W-1:0]     r_prev;
    logic             r_prev_valid;
    logic [NCH*W-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;
    logic [NCH*W-1:0] r_mem [DEPTH];

    logic             w_capturing;
    logic             w_tick;
    logic [W-1:0]     w_cur;
    logic             w_edge;
    logic             w_trig;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;
    logic             w_disc;
    logic             w_drop;
    logic             w_pop;

    assign w_capturing = (r_state == S_PRE) || (r_state == S_POST);
    assign w_full      = (r_used == FULL_LVL);

    // Arm/stop cycles never sample; >= also catches a div_freq lowered below cnt.
    assign w_tick = w_capturing && !bus.pause && !bus.arm && !bus.stop &&
                    (r_cnt >= bus.div_freq);

    always_comb begin
        w_cur = '0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.trig_ch == TCW'(k)) w_cur = bus.ch_data[k*W +: W];
        end
    end

    always_comb begin
        w_edge = 1'b0;
        if (r_prev_valid) begin
            if (bus.trig_rising) w_edge = (r_prev <  bus.trig_level) && (w_cur >= bus.trig_level);
            else                 w_edge = (r_prev >= bus.trig_level) && (w_cur <  bus.trig_level);
        end
    end

    assign w_trig = (r_state == S_PRE) && (bus.force_trig || (w_tick && w_edge));

    assign w_rd   = bus.rd_req && (r_used != '0) && !bus.arm;
    assign w_wr   = w_tick && ((r_state == S_PRE) || ((r_state == S_POST) && !w_full));
    assign w_drop = w_tick && (r_state == S_POST) && w_full;
    // Rolling window: a full PRE write retires the oldest word unless a read already did.
    assign w_disc = w_wr && (r_state == S_PRE) && w_full && !w_rd;
    assign w_pop  = w_rd || w_disc;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        if (bus.stop) begin
            w_state_nxt = S_IDLE;
        end else if (bus.arm) begin
            w_state_nxt = S_PRE;
        end else begin
            case (r_state)
                S_PRE: begin
                    if (w_trig) begin
                        w_rem_nxt   = bus.post_count;
                        w_state_nxt = (bus.post_count == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (w_tick) begin
                        w_rem_nxt = r_rem - ONE;
                        if (r_rem <= ONE) w_state_nxt = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.stop || bus.arm || !w_capturing) w_cnt_nxt = '0;
        else if (bus.pause)                      w_cnt_nxt = r_cnt;
        else if (r_cnt >= bus.div_freq)          w_cnt_nxt = '0;
        else                                     w_cnt_nxt = r_cnt + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_used       <= '0;
            r_overflow   <= 1'b0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (bus.arm && !bus.stop) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_used       <= '0;
            r_overflow   <= 1'b0;
            r_prev_valid <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_used <= r_used + ONE;
                2'b01:   r_used <= r_used - ONE;
                default: r_used <= r_used;
            endcase
            if (w_drop) r_overflow <= 1'b1;
            if (w_tick && (r_state == S_PRE)) begin
                r_prev       <= w_cur;
                r_prev_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.ch_data;
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.fifo_used  = r_used;
    assign bus.fifo_empty = (r_used == '0);
    assign bus.fifo_full  = w_full;
    assign bus.state      = r_state;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_scope_capture_fifo.sv
// Directed bench for scope_capture_fifo with a small FIFO (DEPTH=8) and
// hand-computed expectations for each capture scenario.
module tb_scope_capture_fifo;
    localparam int NCH = 2;
    localparam int W   = 16;
    localparam int AW  = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    scope_capture_fifo_if #(.NCH(NCH), .W(W), .AW(AW)) bus ();

    scope_capture_fifo #(.NCH(NCH), .W(W), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1; step(); bus.arm = 1'b0;
    endtask

    task automatic force_step();
        bus.force_trig = 1'b1; step(); bus.force_trig = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        steps(2);
        n_cmp++; if (bus.state !== 2'd0)      begin n_bad++; $display("FAIL rst_state: got %0d want 0", bus.state); end
        n_cmp++; if (bus.fifo_used !== 4'd0)  begin n_bad++; $display("FAIL rst_used: got %0d want 0", bus.fifo_used); end
        n_cmp++; if (bus.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", bus.fifo_empty); end
        n_cmp++; if (bus.fifo_full !== 1'b0)  begin n_bad++; $display("FAIL rst_full: got %b want 0", bus.fifo_full); end
        n_cmp++; if (bus.rd_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.rd_data !== 32'd0)   begin n_bad++; $display("FAIL rst_rd_data: got %h want 0", bus.rd_data); end
        n_cmp++; if (bus.overflow !== 1'b0)   begin n_bad++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_div_force();
        bus.div_freq = 32'd3; bus.post_count = 4'd5;
        bus.trig_level = 16'hFFFF; bus.trig_rising = 1'b1; bus.trig_ch = 1'b0;
        bus.ch_data = 32'hAAAA_5555;
        pulse_arm();
        n_cmp++; if (bus.state !== 2'd1) begin n_bad++; $display("FAIL t1_pre: got %0d want 1", bus.state); end
        steps(2);
        n_cmp++; if (bus.fifo_used !== 4'd0) begin n_bad++; $display("FAIL t1_no_tick_yet: got %0d want 0", bus.fifo_used); end
        step();
        bus.ch_data = 32'h1234_5678;
        force_step();
        bus.ch_data = 32'hAAAA_5555;
        n_cmp++; if (bus.state !== 2'd2)     begin n_bad++; $display("FAIL t1_post: got %0d want 2", bus.state); end
        n_cmp++; if (bus.fifo_used !== 4'd1) begin n_bad++; $display("FAIL t1_pre_word: got %0d want 1", bus.fifo_used); end
        steps(3);
        n_cmp++; if (bus.fifo_used !== 4'd1) begin n_bad++; $display("FAIL t1_spacing: got %0d want 1", bus.fifo_used); end
        step();
        n_cmp++; if (bus.fifo_used !== 4'd2) begin n_bad++; $display("FAIL t1_tick4: got %0d want 2", bus.fifo_used); end
        steps(15);
        n_cmp++; if (bus.state !== 2'd2 || bus.fifo_used !== 4'd5) begin n_bad++; $display("FAIL t1_before_done: got state %0d used %0d want 2/5", bus.state, bus.fifo_used); end
        step();
        n_cmp++; if (bus.state !== 2'd3 || bus.fifo_used !== 4'd6) begin n_bad++; $display("FAIL t1_done: got state %0d used %0d want 3/6", bus.state, bus.fifo_used); end
        bus.rd_req = 1'b1; step(); bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h1234_5678) begin n_bad++; $display("FAIL t1_first_word: got v=%b %h want 1 12345678", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_trig_rising();
        bus.div_freq = 32'd0; bus.post_count = 4'd2;
        bus.trig_ch = 1'b1; bus.trig_level = 16'd100; bus.trig_rising = 1'b1;
        pulse_arm();
        bus.ch_data = {16'd90, 16'd7};  step();
        bus.ch_data = {16'd95, 16'd7};  step();
        n_cmp++; if (bus.state !== 2'd1) begin n_bad++; $display("FAIL t2_no_trig: got %0d want 1", bus.state); end
        bus.ch_data = {16'd100, 16'd7}; step();
        n_cmp++; if (bus.state !== 2'd2 || bus.fifo_used !== 4'd3) begin n_bad++; $display("FAIL t2_trig: got state %0d used %0d want 2/3", bus.state, bus.fifo_used); end
        bus.ch_data = {16'd101, 16'd7}; steps(2);
        n_cmp++; if (bus.state !== 2'd3 || bus.fifo_used !== 4'd5) begin n_bad++; $display("FAIL t2_done: got state %0d used %0d want 3/5", bus.state, bus.fifo_used); end
        bus.rd_req = 1'b1; steps(3); bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_data !== {16'd100, 16'd7}) begin n_bad++; $display("FAIL t2_trig_word: got %h want 00640007", bus.rd_data); end
    endtask

    task automatic test_trig_falling_zero_post();
        bus.div_freq = 32'd0; bus.post_count = 4'd0;
        bus.trig_ch = 1'b0; bus.trig_level = 16'd50; bus.trig_rising = 1'b0;
        pulse_arm();
        bus.ch_data = {16'd0, 16'd60}; step();
        n_cmp++; if (bus.state !== 2'd1) begin n_bad++; $display("FAIL t2f_pre: got %0d want 1", bus.state); end
        bus.ch_data = {16'd0, 16'd40}; step();
        n_cmp++; if (bus.state !== 2'd3 || bus.fifo_used !== 4'd2) begin n_bad++; $display("FAIL t2f_done: got state %0d used %0d want 3/2", bus.state, bus.fifo_used); end
        steps(3);
        n_cmp++; if (bus.fifo_used !== 4'd2) begin n_bad++; $display("FAIL t2f_no_write_done: got %0d want 2", bus.fifo_used); end
    endtask

    task automatic test_rolling_window();
        bus.div_freq = 32'd0; bus.trig_ch = 1'b0; bus.trig_level = 16'hFFFF; bus.trig_rising = 1'b1;
        pulse_arm();
        for (int k = 0; k < 16; k++) begin
            bus.ch_data = {16'(k), 16'(k)};
            step();
        end
        n_cmp++; if (bus.fifo_used !== 4'd8 || bus.fifo_full !== 1'b1) begin n_bad++; $display("FAIL t3_full: got used %0d full %b want 8/1", bus.fifo_used, bus.fifo_full); end
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        n_cmp++; if (bus.state !== 2'd0 || bus.fifo_used !== 4'd8) begin n_bad++; $display("FAIL t3_stop: got state %0d used %0d want 0/8", bus.state, bus.fifo_used); end
        bus.rd_req = 1'b1; step(); bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h0008_0008) begin n_bad++; $display("FAIL t3_oldest: got v=%b %h want 1 00080008", bus.rd_valid, bus.rd_data); end
        n_cmp++; if (bus.fifo_used !== 4'd7) begin n_bad++; $display("FAIL t3_used_after_rd: got %0d want 7", bus.fifo_used); end
    endtask

    task automatic test_post_overflow();
        bus.div_freq = 32'd0; bus.post_count = 4'd12; bus.trig_level = 16'hFFFF;
        bus.ch_data = 32'h0000_0001;
        pulse_arm();
        force_step();
        steps(11);
        n_cmp++; if (bus.state !== 2'd2) begin n_bad++; $display("FAIL t4_still_post: got %0d want 2", bus.state); end
        step();
        n_cmp++; if (bus.state !== 2'd3)     begin n_bad++; $display("FAIL t4_done: got %0d want 3", bus.state); end
        n_cmp++; if (bus.fifo_full !== 1'b1 || bus.fifo_used !== 4'd8) begin n_bad++; $display("FAIL t4_full: got full %b used %0d want 1/8", bus.fifo_full, bus.fifo_used); end
        n_cmp++; if (bus.overflow !== 1'b1)  begin n_bad++; $display("FAIL t4_overflow: got %b want 1", bus.overflow); end
    endtask

    task automatic test_empty_read_full_rw();
        bus.div_freq = 32'd0; bus.trig_ch = 1'b0; bus.trig_level = 16'hFFFF; bus.trig_rising = 1'b1;
        bus.pause = 1'b1;
        pulse_arm();
        n_cmp++; if (bus.overflow !== 1'b0 || bus.fifo_used !== 4'd0) begin n_bad++; $display("FAIL t5_arm_clear: got ovf %b used %0d want 0/0", bus.overflow, bus.fifo_used); end
        bus.rd_req = 1'b1; step(); bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL t5_empty_rd_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.rd_data !== 32'h0008_0008) begin n_bad++; $display("FAIL t5_empty_rd_hold: got %h want 00080008", bus.rd_data); end
        bus.pause = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.ch_data = {16'(k), 16'(k)};
            step();
        end
        n_cmp++; if (bus.fifo_used !== 4'd8) begin n_bad++; $display("FAIL t5_fill: got %0d want 8", bus.fifo_used); end
        bus.ch_data = {16'd8, 16'd8}; bus.rd_req = 1'b1; step(); bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h0000_0000 || bus.fifo_used !== 4'd8) begin n_bad++; $display("FAIL t5_rw_full: got v=%b %h used %0d want 1 00000000 8", bus.rd_valid, bus.rd_data, bus.fifo_used); end
        bus.ch_data = {16'd9, 16'd9}; step();
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        bus.rd_req = 1'b1; step(); bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_data !== 32'h0002_0002) begin n_bad++; $display("FAIL t5_discard_oldest: got %h want 00020002", bus.rd_data); end
    endtask

    task automatic test_pause_stop_reset();
        bus.div_freq = 32'd0; bus.post_count = 4'd5; bus.trig_level = 16'hFFFF;
        bus.ch_data = 32'h0000_00AB;
        pulse_arm();
        force_step();
        steps(2);
        bus.pause = 1'b1; steps(20);
        n_cmp++; if (bus.state !== 2'd2 || bus.fifo_used !== 4'd3) begin n_bad++; $display("FAIL t6_paused: got state %0d used %0d want 2/3", bus.state, bus.fifo_used); end
        bus.pause = 1'b0; steps(2);
        n_cmp++; if (bus.state !== 2'd2 || bus.fifo_used !== 4'd5) begin n_bad++; $display("FAIL t6_rem_frozen: got state %0d used %0d want 2/5", bus.state, bus.fifo_used); end
        step();
        n_cmp++; if (bus.state !== 2'd3 || bus.fifo_used !== 4'd6) begin n_bad++; $display("FAIL t6_done: got state %0d used %0d want 3/6", bus.state, bus.fifo_used); end
        pulse_arm();
        force_step();
        steps(2);
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        n_cmp++; if (bus.state !== 2'd0 || bus.fifo_used !== 4'd3) begin n_bad++; $display("FAIL t6_stop: got state %0d used %0d want 0/3", bus.state, bus.fifo_used); end
        pulse_arm();
        force_step();
        step();
        bus.rd_req = 1'b1; step(); bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.fifo_used !== 4'd2) begin n_bad++; $display("FAIL t6_rw_post: got v=%b used %0d want 1/2", bus.rd_valid, bus.fifo_used); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.state !== 2'd0 || bus.fifo_used !== 4'd0 || bus.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL t6_async_rst: got state %0d used %0d empty %b want 0/0/1", bus.state, bus.fifo_used, bus.fifo_empty); end
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0 || bus.overflow !== 1'b0 || bus.fifo_full !== 1'b0) begin n_bad++; $display("FAIL t6_async_rst_out: got v=%b %h ovf %b full %b want 0 0 0 0", bus.rd_valid, bus.rd_data, bus.overflow, bus.fifo_full); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        bus.ch_data = '0; bus.div_freq = '0; bus.arm = 1'b0; bus.stop = 1'b0;
        bus.pause = 1'b0; bus.force_trig = 1'b0; bus.trig_ch = '0; bus.trig_level = '0;
        bus.trig_rising = 1'b1; bus.post_count = '0; bus.rd_req = 1'b0;
        test_reset();
        test_div_force();
        test_trig_rising();
        test_trig_falling_zero_post();
        test_rolling_window();
        test_post_overflow();
        test_empty_read_full_rw();
        test_pause_stop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
